// File: rtl/dm_dump_pkg.sv
// Shared types and defaults for the end-of-simulation result dump controller.
package dm_dump_pkg;

  localparam int unsigned ADDR_W = 14;
  localparam int unsigned DATA_W = 32;

  localparam logic [ADDR_W-1:0] DEF_SIM_END_ADDR    = 14'h3fff;
  localparam logic [ADDR_W-1:0] DEF_TEST_START_ADDR = 14'h2000;
  localparam logic [DATA_W-1:0] DEF_END_CODE        = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HALT,
    ST_READ,
    ST_WAIT,
    ST_SEND,
    ST_DONE
  } state_e;

  // One word of the result stream as presented on the output handshake.
  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [ADDR_W-1:0] index;
    logic              last;
  } beat_t;

  // Limit the requested length to the size of the result region.
  function automatic logic [ADDR_W-1:0] clamp_len(input logic [ADDR_W-1:0] len,
                                                  input logic [ADDR_W-1:0] max_len);
    return (len > max_len) ? max_len : len;
  endfunction

endpackage

// File: rtl/dm_dump_ctrl_if.sv
// CPU snoop, data-memory read port and result-stream signals of the dump controller.
interface dm_dump_ctrl_if;
  import dm_dump_pkg::*;

  logic [3:0]        cpu_dm_we;
  logic [ADDR_W-1:0] cpu_dm_addr;
  logic [DATA_W-1:0] cpu_dm_wdata;
  logic [ADDR_W-1:0] dump_len;
  logic              dm_rd_en;
  logic [ADDR_W-1:0] dm_rd_addr;
  logic [DATA_W-1:0] dm_rd_data;
  logic              cpu_halt;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [ADDR_W-1:0] out_index;
  logic              out_last;
  logic              dump_done;

  // Dump controller side.
  modport slave (
    input  cpu_dm_we, cpu_dm_addr, cpu_dm_wdata, dump_len, dm_rd_data, out_ready,
    output dm_rd_en, dm_rd_addr, cpu_halt, out_valid, out_data, out_index, out_last,
           dump_done
  );

  // Environment side: CPU, data memory and result sink.
  modport master (
    output cpu_dm_we, cpu_dm_addr, cpu_dm_wdata, dump_len, dm_rd_data, out_ready,
    input  dm_rd_en, dm_rd_addr, cpu_halt, out_valid, out_data, out_index, out_last,
           dump_done
  );

endinterface

// File: rtl/dm_dump_ctrl.sv
// Watches the CPU for the end-of-simulation mailbox write, halts the CPU and
// streams the result region out of data memory one word per handshake.
module dm_dump_ctrl
  import dm_dump_pkg::*;
#(
  parameter logic [ADDR_W-1:0] SIM_END_ADDR    = DEF_SIM_END_ADDR,
  parameter logic [ADDR_W-1:0] TEST_START_ADDR = DEF_TEST_START_ADDR,
  parameter logic [DATA_W-1:0] END_CODE        = DEF_END_CODE
) (
  input logic           clk,
  input logic           rst,
  dm_dump_ctrl_if.slave bus
);

  localparam logic [ADDR_W-1:0] MAX_LEN = SIM_END_ADDR - TEST_START_ADDR;

  state_e            r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_idx, w_idx_nxt;
  logic [ADDR_W-1:0] r_len, w_len_nxt;
  logic              r_cpu_halt, w_cpu_halt_nxt;
  logic              r_rd_en, w_rd_en_nxt;
  logic [ADDR_W-1:0] r_rd_addr, w_rd_addr_nxt;
  beat_t             r_beat, w_beat_nxt;
  logic              r_valid, w_valid_nxt;
  logic              r_done, w_done_nxt;

  logic              w_trigger;
  logic [ADDR_W-1:0] w_len_clamped;
  logic [ADDR_W-1:0] w_idx_inc;

  // Full-word END_CODE store to the mailbox address.
  assign w_trigger     = (bus.cpu_dm_we == 4'b1111) && (bus.cpu_dm_addr == SIM_END_ADDR) &&
                         (bus.cpu_dm_wdata == END_CODE);
  assign w_len_clamped = clamp_len(bus.dump_len, MAX_LEN);
  assign w_idx_inc     = r_idx + ADDR_W'(1);

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    w_state_nxt    = r_state;
    w_idx_nxt      = r_idx;
    w_len_nxt      = r_len;
    w_cpu_halt_nxt = r_cpu_halt;
    w_rd_en_nxt    = 1'b0;
    w_rd_addr_nxt  = r_rd_addr;
    w_beat_nxt     = r_beat;
    w_valid_nxt    = r_valid;
    w_done_nxt     = r_done;

    unique case (r_state)
      ST_IDLE: begin
        if (w_trigger) begin
          w_state_nxt    = ST_HALT;
          w_cpu_halt_nxt = 1'b1;
        end
      end
      ST_HALT: begin
        w_len_nxt = w_len_clamped;
        w_idx_nxt = '0;
        if (w_len_clamped == '0) begin
          w_state_nxt = ST_DONE;
          w_done_nxt  = 1'b1;
        end else begin
          w_state_nxt   = ST_READ;
          w_rd_en_nxt   = 1'b1;
          w_rd_addr_nxt = TEST_START_ADDR;
        end
      end
      ST_READ: begin
        w_state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        w_beat_nxt.data  = bus.dm_rd_data;
        w_beat_nxt.index = r_idx;
        w_beat_nxt.last  = (r_idx == (r_len - ADDR_W'(1)));
        w_valid_nxt      = 1'b1;
        w_state_nxt      = ST_SEND;
      end
      ST_SEND: begin
        if (r_valid && bus.out_ready) begin
          w_valid_nxt = 1'b0;
          if (r_beat.last) begin
            w_state_nxt = ST_DONE;
            w_done_nxt  = 1'b1;
          end else begin
            w_idx_nxt     = w_idx_inc;
            w_state_nxt   = ST_READ;
            w_rd_en_nxt   = 1'b1;
            w_rd_addr_nxt = TEST_START_ADDR + w_idx_inc;
          end
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_DONE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State and output registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= ST_IDLE;
      r_idx      <= '0;
      r_len      <= '0;
      r_cpu_halt <= 1'b0;
      r_rd_en    <= 1'b0;
      r_rd_addr  <= '0;
      r_beat     <= '0;
      r_valid    <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_idx      <= w_idx_nxt;
      r_len      <= w_len_nxt;
      r_cpu_halt <= w_cpu_halt_nxt;
      r_rd_en    <= w_rd_en_nxt;
      r_rd_addr  <= w_rd_addr_nxt;
      r_beat     <= w_beat_nxt;
      r_valid    <= w_valid_nxt;
      r_done     <= w_done_nxt;
    end
  end

  assign bus.cpu_halt   = r_cpu_halt;
  assign bus.dm_rd_en   = r_rd_en;
  assign bus.dm_rd_addr = r_rd_addr;
  assign bus.out_valid  = r_valid;
  assign bus.out_data   = r_beat.data;
  assign bus.out_index  = r_beat.index;
  assign bus.out_last   = r_beat.last;
  assign bus.dump_done  = r_done;

endmodule

// File: tb/tb_dm_dump_ctrl.sv
// Self-checking bench for dm_dump_ctrl: a transaction-level model predicts the
// read addresses and result beats, one negedge process compares every cycle.
module tb_dm_dump_ctrl;

  localparam logic [13:0] SIM_END   = 14'h3fff;
  localparam logic [13:0] TST_START = 14'h2000;
  localparam logic [31:0] ENDC      = 32'hFFFF_FFFF;
  localparam int          MAX_BEATS = 32'h3fff - 32'h2000;

  logic clk;
  logic rst;
  logic stall_mode;
  int   n_checks;
  int   n_fail;

  logic [31:0] mem [0:16383];

  dm_dump_ctrl_if u_if ();

  dm_dump_ctrl #(
    .SIM_END_ADDR   (SIM_END),
    .TEST_START_ADDR(TST_START),
    .END_CODE       (ENDC)
  ) u_dut (
    .clk(clk),
    .rst(rst),
    .bus(u_if.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Data memory read port: data valid one cycle after the strobe.
  initial begin
    u_if.dm_rd_data = '0;
    forever begin
      @(posedge clk);
      if (u_if.dm_rd_en) u_if.dm_rd_data <= mem[u_if.dm_rd_addr];
    end
  end

  // Result sink: always ready, or hold ready low five cycles per offered beat.
  initial begin
    int cnt;
    cnt = 0;
    u_if.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (!stall_mode) begin
        u_if.out_ready = 1'b1;
      end else if (u_if.out_ready) begin
        u_if.out_ready = 1'b0;
        cnt = 0;
      end else if (u_if.out_valid) begin
        cnt++;
        if (cnt >= 5) u_if.out_ready = 1'b1;
      end
    end
  end

  // Model state.
  logic        m_armed, m_halt, m_done;
  int          m_halt_in, m_done_in;
  logic [13:0] rd_q[$];
  logic [31:0] exp_data[$];
  logic [13:0] exp_idx[$];
  logic        exp_last[$];
  int          reads_since_beat;
  logic        p_valid, p_ready, p_last;
  logic [31:0] p_data;
  logic [13:0] p_idx;
  logic [13:0] last_rd_addr;
  logic [31:0] log_data[$];
  logic [13:0] log_idx[$];
  logic        log_last[$];

  // Model update and per-cycle comparison.
  always @(negedge clk) begin
    if (!rst) begin
      m_armed = 1'b1; m_halt = 1'b0; m_done = 1'b0;
      m_halt_in = 0; m_done_in = 0;
      rd_q.delete(); exp_data.delete(); exp_idx.delete(); exp_last.delete();
      reads_since_beat = 0;
      p_valid = 1'b0; p_ready = 1'b0;
    end else begin
      if (m_halt_in > 0) begin m_halt_in--; if (m_halt_in == 0) m_halt = 1'b1; end
      if (m_done_in > 0) begin m_done_in--; if (m_done_in == 0) m_done = 1'b1; end

      check("cpu_halt", 32'(u_if.cpu_halt), 32'(m_halt));
      check("dump_done", 32'(u_if.dump_done), 32'(m_done));
      if (m_done) check("valid_in_done", 32'(u_if.out_valid), 32'd0);

      if (p_valid && !p_ready) begin
        check("hold_valid", 32'(u_if.out_valid), 32'd1);
        check("hold_data", u_if.out_data, p_data);
        check("hold_index", 32'(u_if.out_index), 32'(p_idx));
        check("hold_last", 32'(u_if.out_last), 32'(p_last));
      end

      if (u_if.dm_rd_en) begin
        if (rd_q.size() == 0) begin
          check("rd_unexpected", 32'(u_if.dm_rd_en), 32'd0);
        end else begin
          check("rd_addr", 32'(u_if.dm_rd_addr), 32'(rd_q.pop_front()));
          check("rd_per_word", 32'(reads_since_beat), 32'd0);
          reads_since_beat++;
          last_rd_addr = u_if.dm_rd_addr;
        end
      end

      if (u_if.out_valid && u_if.out_ready) begin
        if (exp_data.size() == 0) begin
          check("beat_unexpected", 32'(u_if.out_valid), 32'd0);
        end else begin
          check("beat_data", u_if.out_data, exp_data.pop_front());
          check("beat_index", 32'(u_if.out_index), 32'(exp_idx.pop_front()));
          check("beat_last", 32'(u_if.out_last), 32'(exp_last.pop_front()));
          check("reads_for_beat", 32'(reads_since_beat), 32'd1);
          reads_since_beat = 0;
          log_data.push_back(u_if.out_data);
          log_idx.push_back(u_if.out_index);
          log_last.push_back(u_if.out_last);
          if (exp_data.size() == 0) m_done_in = 1;
        end
      end

      if (m_armed && u_if.cpu_dm_we == 4'b1111 && u_if.cpu_dm_addr == SIM_END &&
          u_if.cpu_dm_wdata == ENDC) begin
        int n;
        n = (int'(u_if.dump_len) > MAX_BEATS) ? MAX_BEATS : int'(u_if.dump_len);
        m_armed = 1'b0;
        m_halt_in = 1;
        if (n == 0) m_done_in = 2;
        for (int i = 0; i < n; i++) begin
          rd_q.push_back(14'(int'(TST_START) + i));
          exp_data.push_back(mem[int'(TST_START) + i]);
          exp_idx.push_back(14'(i));
          exp_last.push_back(i == n - 1);
        end
      end

      p_valid = u_if.out_valid;
      p_ready = u_if.out_ready;
      p_data  = u_if.out_data;
      p_idx   = u_if.out_index;
      p_last  = u_if.out_last;
    end
  end

  task automatic cpu_write(input logic [3:0] we, input logic [13:0] addr, input logic [31:0] wd);
    u_if.cpu_dm_we    = we;
    u_if.cpu_dm_addr  = addr;
    u_if.cpu_dm_wdata = wd;
    @(posedge clk);
    #1;
    u_if.cpu_dm_we    = 4'b0000;
    u_if.cpu_dm_addr  = '0;
    u_if.cpu_dm_wdata = '0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    log_data.delete(); log_idx.delete(); log_last.delete();
  endtask

  task automatic wait_done(input int max_cyc);
    int c;
    c = 0;
    while (!u_if.dump_done && c < max_cyc) begin
      @(posedge clk);
      #1;
      c++;
    end
    check("done_reached", 32'(u_if.dump_done), 32'd1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_cpu_halt"}, 32'(u_if.cpu_halt), 32'd0);
    check({tag, "_rd_en"}, 32'(u_if.dm_rd_en), 32'd0);
    check({tag, "_rd_addr"}, 32'(u_if.dm_rd_addr), 32'd0);
    check({tag, "_valid"}, 32'(u_if.out_valid), 32'd0);
    check({tag, "_data"}, u_if.out_data, 32'd0);
    check({tag, "_index"}, 32'(u_if.out_index), 32'd0);
    check({tag, "_last"}, 32'(u_if.out_last), 32'd0);
    check({tag, "_done"}, 32'(u_if.dump_done), 32'd0);
  endtask

  initial begin
    int c;
    n_checks = 0;
    n_fail = 0;
    stall_mode = 1'b0;
    rst = 1'b0;
    u_if.cpu_dm_we = '0; u_if.cpu_dm_addr = '0; u_if.cpu_dm_wdata = '0; u_if.dump_len = '0;
    for (int i = 0; i < 16384; i++) mem[i] = 32'h5EED_0000 ^ (32'(i) << 4) ^ 32'(i);
    mem[16'h2000] = 32'hA5A5_0001;
    mem[16'h2001] = 32'hB6B6_0002;
    mem[16'h2002] = 32'hC7C7_0003;

    // Reset values.
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    do_reset();

    // Three-word dump with an always-ready sink.
    u_if.dump_len = 14'd3;
    repeat (2) @(posedge clk);
    #1;
    cpu_write(4'b1111, SIM_END, ENDC);
    check("halt_after_trigger", 32'(u_if.cpu_halt), 32'd1);
    wait_done(100);
    check("t1_beats", 32'(log_data.size()), 32'd3);
    if (log_data.size() == 3) begin
      check("t1_data0", log_data[0], 32'hA5A5_0001);
      check("t1_data2", log_data[2], 32'hC7C7_0003);
      check("t1_idx2", 32'(log_idx[2]), 32'd2);
      check("t1_last1", 32'(log_last[1]), 32'd0);
      check("t1_last2", 32'(log_last[2]), 32'd1);
    end
    cpu_write(4'b1111, SIM_END, ENDC);
    repeat (10) @(posedge clk);
    #1;
    check("t1_done_sticky", 32'(u_if.dump_done), 32'd1);

    // Partial-byte and wrong-value mailbox writes do not trigger.
    do_reset();
    cpu_write(4'b0011, SIM_END, ENDC);
    cpu_write(4'b1111, SIM_END, 32'h0000_0001);
    cpu_write(4'b1111, 14'h3ffe, ENDC);
    repeat (10) @(posedge clk);
    #1;
    check("t2_no_halt", 32'(u_if.cpu_halt), 32'd0);
    check("t2_no_done", 32'(u_if.dump_done), 32'd0);

    // Zero-length dump goes straight to done.
    do_reset();
    u_if.dump_len = 14'd0;
    cpu_write(4'b1111, SIM_END, ENDC);
    check("t3_done_in_halt", 32'(u_if.dump_done), 32'd0);
    @(posedge clk);
    #1;
    check("t3_done", 32'(u_if.dump_done), 32'd1);
    check("t3_no_valid", 32'(u_if.out_valid), 32'd0);
    repeat (5) @(posedge clk);
    #1;
    check("t3_beats", 32'(log_data.size()), 32'd0);

    // Back-pressured two-word dump.
    do_reset();
    stall_mode = 1'b1;
    u_if.dump_len = 14'd2;
    cpu_write(4'b1111, SIM_END, ENDC);
    wait_done(200);
    check("t4_beats", 32'(log_data.size()), 32'd2);
    if (log_data.size() == 2) check("t4_data1", log_data[1], mem[16'h2001]);
    stall_mode = 1'b0;

    // Oversized length clamps to the full result region.
    do_reset();
    u_if.dump_len = 14'h3fff;
    cpu_write(4'b1111, SIM_END, ENDC);
    wait_done(30000);
    check("t5_beats", 32'(log_data.size()), 32'd8191);
    if (log_data.size() == 8191) begin
      check("t5_last_idx", 32'(log_idx[8190]), 32'd8190);
      check("t5_last_flag", 32'(log_last[8190]), 32'd1);
      check("t5_prev_flag", 32'(log_last[8189]), 32'd0);
    end
    check("t5_last_rd_addr", 32'(last_rd_addr), 32'h3ffe);

    // Reset during the second beat of a four-word dump.
    do_reset();
    u_if.dump_len = 14'd4;
    cpu_write(4'b1111, SIM_END, ENDC);
    c = 0;
    while (!(u_if.out_valid && u_if.out_index == 14'd1) && c < 100) begin
      @(posedge clk);
      #1;
      c++;
    end
    check("t6_reached_beat1", 32'(u_if.out_valid), 32'd1);
    rst = 1'b0;
    #1;
    check_all_zero("t6_abort");
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check("t6_beats", 32'(log_data.size()), 32'd1);
    check("t6_no_halt", 32'(u_if.cpu_halt), 32'd0);
    u_if.dump_len = 14'd1;
    cpu_write(4'b1111, SIM_END, ENDC);
    wait_done(100);
    check("t6_rearm_beats", 32'(log_data.size()), 32'd2);
    if (log_data.size() == 2) check("t6_rearm_data", log_data[1], mem[16'h2000]);

    repeat (3) @(posedge clk);
    check("exp_drained", 32'(exp_data.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dm_dump_ctrl.md
DM_DUMP_CTRL -- requirements
Module: dm_dump_ctrl

Interface
REQ-001 Parameter SIM_END_ADDR, 14'h3fff, word address of the end-of-simulation mailbox.
REQ-002 Parameter TEST_START_ADDR, 14'h2000, first word address of the result region.
REQ-003 Parameter END_CODE, 32'hFFFF_FFFF, mailbox value that signals program completion.
REQ-004 clk  in  1  single clock; all state changes on the rising edge.
REQ-005 rst  in  1  asynchronous, active-low reset.
REQ-006 cpu_dm_we  in  4  CPU data-memory byte write enables, observed, not driven.
REQ-007 cpu_dm_addr  in  14  CPU data-memory word address.
REQ-008 cpu_dm_wdata  in  32  CPU data-memory write data.
REQ-009 dump_len  in  14  number of result words to dump.
REQ-010 dm_rd_en  out  1  read strobe to the data-memory read port.
REQ-011 dm_rd_addr  out  14  word address for that read.
REQ-012 dm_rd_data  in  32  read data, valid exactly one cycle after dm_rd_en.
REQ-013 cpu_halt  out  1  freezes the CPU PC and DM writes while high.
REQ-014 out_valid / out_ready  out / in  1 / 1  result-stream handshake.
REQ-015 out_data  out  32  result word; out_index out 14 word offset from TEST_START_ADDR; out_last out 1 final word.
REQ-016 dump_done  out  1  sticky; dump complete.

Function
REQ-017 Trigger SHALL be cpu_dm_we==4'b1111, cpu_dm_addr==SIM_END_ADDR and cpu_dm_wdata==END_CODE in the same cycle while in IDLE; partial-byte writes and other values SHALL NOT trigger.
REQ-018 FSM states SHALL be IDLE, HALT, READ, WAIT, SEND, DONE.
REQ-019 IDLE->HALT on trigger; cpu_halt SHALL go high the cycle after the trigger edge and stay high until reset.
REQ-020 In HALT (one cycle), dump_len SHALL be latched, clamped to SIM_END_ADDR-TEST_START_ADDR (8191); latched length 0 -> DONE, else -> READ with index 0.
REQ-021 READ SHALL assert dm_rd_en for exactly one cycle with dm_rd_addr=TEST_START_ADDR+index, then -> WAIT.
REQ-022 WAIT SHALL capture dm_rd_data into out_data, then -> SEND.
REQ-023 In SEND, out_valid SHALL be high, with out_data, out_index and out_last held stable until out_valid&&out_ready.
REQ-024 out_last SHALL be high only when index == latched length-1.
REQ-025 On handshake: if out_last, -> DONE; else index+1 and -> READ; minimum 3 cycles per word.
REQ-026 DONE SHALL hold dump_done=1 and out_valid=0, and ignore all inputs until reset.
REQ-027 CPU writes after the trigger, including further END_CODE writes, SHALL be ignored.
REQ-028 dm_rd_en SHALL be 0 in every state except READ.

Reset
REQ-029 rst low SHALL force, asynchronously, IDLE, index 0, cpu_halt=0, dm_rd_en=0, dm_rd_addr=0, out_valid=0, out_data=0, out_index=0, out_last=0, dump_done=0.
REQ-030 Reset mid-dump SHALL abort with no further stream beats.
REQ-031 After reset release, a fresh trigger SHALL be required.

Structure
REQ-032 A shared package dm_dump_pkg SHALL hold the FSM state enumeration, address width (14), data width (32) and the default SIM_END/TEST_START/END_CODE constants.
REQ-033 The block SHALL be flat, with no sub-modules.

Verification
REQ-034 Write 32'hFFFF_FFFF with we=4'b1111 at 14'h3fff, dump_len=3, DM[0x2000..0x2002]=A,B,C, out_ready=1 -> cpu_halt high the next cycle; beats A/0, B/1, C/2 with out_last on C; dump_done asserted.
REQ-035 Write 32'hFFFF_FFFF with we=4'b0011 at 14'h3fff, then 32'h0000_0001 with full we at 14'h3fff -> no trigger; cpu_halt=0; dm_rd_en never asserted.
REQ-036 Trigger with dump_len=0 -> DONE two cycles after the trigger edge; no out_valid pulse; dump_done=1.
REQ-037 dump_len=2, out_ready held low 5 cycles per beat -> out_valid, out_data and out_index stable throughout; exactly one dm_rd_en per word.
REQ-038 dump_len=14'h3fff -> clamped to 8191 beats; final dm_rd_addr=14'h3ffe; out_last on out_index 8190.
REQ-039 rst low during the second SEND of a 4-word dump -> all outputs 0 immediately; no beats after release until a new trigger.
